// File: rtl/uart_apb_cmd_master.sv
// UART byte-command to APB initiator bridge: parses 'W'/'R' frames, runs one
// APB transfer per frame and streams back ACK/NAK plus read data.
module uart_apb_cmd_master #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int APB_TIMEOUT    = 256,
   parameter int FRAME_TIMEOUT  = 500000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                rx_byte,
   input  logic                      rx_byte_valid,
   output logic [7:0]                tx_byte,
   output logic                      tx_byte_valid,
   input  logic                      tx_byte_ready,
   output logic                      psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [APB_ADDR_WIDTH-1:0] paddr,
   output logic [31:0]               pwdata,
   input  logic [31:0]               prdata,
   input  logic                      pready,
   input  logic                      pslverr,
   output logic                      busy,
   output logic                      rx_drop,
   output logic                      frame_err
);

   localparam int              ACW      = $clog2(APB_TIMEOUT + 1);
   localparam logic [ACW-1:0]  ACC_LAST = ACW'(APB_TIMEOUT);
   localparam bit              FT_EN    = (FRAME_TIMEOUT > 0);
   localparam logic [31:0]     FT_LAST  = FT_EN ? 32'(FRAME_TIMEOUT - 1) : 32'h0;

   localparam logic [7:0] CMD_W   = 8'h57;
   localparam logic [7:0] CMD_R   = 8'h52;
   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;
   localparam logic [7:0] RSP_UNK = 8'h3F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_ADDR,
      S_GET_DATA,
      S_SETUP,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t                    state_q;
   logic [2:0]                cnt_q;
   logic [15:0]               addr_q;
   logic [31:0]               data_q;
   logic                      is_wr_q;
   logic [31:0]               idle_q;
   logic [ACW-1:0]            acc_q;
   logic                      psel_q;
   logic                      penable_q;
   logic                      pwrite_q;
   logic [APB_ADDR_WIDTH-1:0] paddr_q;
   logic [31:0]               pwdata_q;
   logic [7:0]                tx_byte_q;
   logic                      tx_valid_q;
   logic                      rx_drop_q;
   logic                      frame_err_q;

   logic [15:0] addr_d;
   logic [31:0] data_d;
   logic        frame_expired;
   logic        rx_blocked;

   assign addr_d        = {addr_q[7:0], rx_byte};
   assign data_d        = {data_q[23:0], rx_byte};
   assign frame_expired = FT_EN && (idle_q == FT_LAST);
   // Parser is frozen while a transfer or response is in flight
   assign rx_blocked    = (state_q == S_SETUP) || (state_q == S_ACCESS) || (state_q == S_RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         addr_q      <= 16'h0;
         data_q      <= 32'h0;
         is_wr_q     <= 1'b0;
         idle_q      <= 32'h0;
         acc_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= 32'h0;
         tx_byte_q   <= 8'h0;
         tx_valid_q  <= 1'b0;
         rx_drop_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_drop_q   <= rx_byte_valid && rx_blocked;
         frame_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (rx_byte_valid) begin
                  cnt_q  <= 3'd0;
                  idle_q <= 32'h0;
                  if (rx_byte == CMD_W || rx_byte == CMD_R) begin
                     is_wr_q <= (rx_byte == CMD_W);
                     state_q <= S_GET_ADDR;
                  end else begin
                     tx_byte_q  <= RSP_UNK;
                     tx_valid_q <= 1'b1;
                     state_q    <= S_RESP;
                  end
               end
            end
            S_GET_ADDR: begin
               if (rx_byte_valid) begin
                  addr_q <= addr_d;
                  idle_q <= 32'h0;
                  cnt_q  <= cnt_q + 3'd1;
                  if (cnt_q == 3'd1) begin
                     cnt_q <= 3'd0;
                     if (is_wr_q) begin
                        state_q <= S_GET_DATA;
                     end else begin
                        state_q  <= S_SETUP;
                        psel_q   <= 1'b1;
                        pwrite_q <= 1'b0;
                        paddr_q  <= addr_d[APB_ADDR_WIDTH-1:0];
                     end
                  end
               end else if (frame_expired) begin
                  state_q     <= S_IDLE;
                  frame_err_q <= 1'b1;
               end else begin
                  idle_q <= idle_q + 32'd1;
               end
            end
            S_GET_DATA: begin
               if (rx_byte_valid) begin
                  data_q <= data_d;
                  idle_q <= 32'h0;
                  cnt_q  <= cnt_q + 3'd1;
                  if (cnt_q == 3'd3) begin
                     cnt_q    <= 3'd0;
                     state_q  <= S_SETUP;
                     psel_q   <= 1'b1;
                     pwrite_q <= 1'b1;
                     paddr_q  <= addr_q[APB_ADDR_WIDTH-1:0];
                     pwdata_q <= data_d;
                  end
               end else if (frame_expired) begin
                  state_q     <= S_IDLE;
                  frame_err_q <= 1'b1;
               end else begin
                  idle_q <= idle_q + 32'd1;
               end
            end
            S_SETUP: begin
               penable_q <= 1'b1;
               acc_q     <= ACW'(1);
               state_q   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (pready) begin
                  psel_q     <= 1'b0;
                  penable_q  <= 1'b0;
                  tx_valid_q <= 1'b1;
                  state_q    <= S_RESP;
                  if (pslverr) begin
                     tx_byte_q <= RSP_NAK;
                     cnt_q     <= 3'd0;
                  end else begin
                     tx_byte_q <= RSP_ACK;
                     data_q    <= prdata;
                     cnt_q     <= pwrite_q ? 3'd0 : 3'd4;
                  end
               end else if (acc_q == ACC_LAST) begin
                  psel_q     <= 1'b0;
                  penable_q  <= 1'b0;
                  tx_valid_q <= 1'b1;
                  tx_byte_q  <= RSP_NAK;
                  cnt_q      <= 3'd0;
                  state_q    <= S_RESP;
               end else begin
                  acc_q <= acc_q + ACW'(1);
               end
            end
            S_RESP: begin
               // cnt_q holds the number of read-data bytes still to follow
               if (tx_byte_ready) begin
                  if (cnt_q == 3'd0) begin
                     tx_valid_q <= 1'b0;
                     state_q    <= S_IDLE;
                  end else begin
                     tx_byte_q <= data_q[31:24];
                     data_q    <= {data_q[23:0], 8'h00};
                     cnt_q     <= cnt_q - 3'd1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign psel          = psel_q;
   assign penable       = penable_q;
   assign pwrite        = pwrite_q;
   assign paddr         = paddr_q;
   assign pwdata        = pwdata_q;
   assign tx_byte       = tx_byte_q;
   assign tx_byte_valid = tx_valid_q;
   assign busy          = (state_q != S_IDLE);
   assign rx_drop       = rx_drop_q;
   assign frame_err     = frame_err_q;

endmodule

// File: doc/uart_apb_cmd_master.md
# uart_apb_cmd_master

- Byte-command bridge that makes a UART link an APB initiator, for host/debug access to the peripheral bus.
- Consumes received bytes, parses write/read command frames, runs one APB transfer per frame, and returns acknowledge/read-data bytes on a handshaked byte stream.
- Sits between the UART byte receiver/transmitter pair and the APB peripheral bus; the UART peripherals on that bus are its targets.

## Interface
Parameters:
- APB_ADDR_WIDTH, 12, paddr width; the low bits of the received 16-bit address are used.
- APB_TIMEOUT, 256, access-phase cycles without pready before abort (≥1).
- FRAME_TIMEOUT, 500000, idle cycles allowed between bytes of one frame; 0 disables.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_byte  in  8  received byte.
- rx_byte_valid  in  1  one-cycle pulse per received byte; no backpressure.
- tx_byte  out  8  response byte.
- tx_byte_valid  out  1  response byte valid.
- tx_byte_ready  in  1  transmitter accepts tx_byte.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  APB_ADDR_WIDTH  APB address.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready, pslverr  in  1 each  APB completion and error.
- busy  out  1  high whenever state ≠ IDLE.
- rx_drop  out  1  one-cycle pulse when a received byte is discarded.
- frame_err  out  1  one-cycle pulse when a partial frame is discarded on timeout.

## Operation
- Write frame: 0x57 'W', ADDR[15:8], ADDR[7:0], D[31:24], D[23:16], D[15:8], D[7:0].
- Read frame: 0x52 'R', ADDR[15:8], ADDR[7:0].
- Responses:
  - Write OK: 0x06.
  - Read OK: 0x06 followed by prdata MSB first (5 bytes).
  - Any pslverr or timeout: single byte 0x15.
  - Unknown command byte: single byte 0x3F; no APB transfer.
- States: IDLE → GET_ADDR (2 bytes) → GET_DATA (4 bytes, write only) → SETUP → ACCESS → RESP → IDLE.
  - Unknown command: IDLE → RESP directly.
- Byte counter: 3 bits.
  - Address shift register: 16 bits.
  - Data shift register: 32 bits, MSB first.
  - paddr = addr[APB_ADDR_WIDTH-1:0].
- APB sequencing:
  - SETUP: psel=1, penable=0, with paddr/pwrite/pwdata stable.
  - ACCESS: psel=1, penable=1, held until pready=1.
  - prdata and pslverr are sampled on the pready cycle.
  - psel and penable are low the following cycle.
- APB timeout: the access-cycle counter starts at 1 in the first ACCESS cycle.
  - If pready is still 0 in cycle APB_TIMEOUT, the transfer aborts: psel and penable drop next cycle and the response is 0x15.
  - A pready arriving in cycle APB_TIMEOUT counts as completion.
- Frame timeout:
  - The idle counter clears on each accepted byte in GET_ADDR/GET_DATA.
  - When it reaches FRAME_TIMEOUT: return to IDLE, pulse frame_err, send no response.
- Bytes arriving in SETUP, ACCESS or RESP are discarded with an rx_drop pulse. The frame parser is unaffected.
- Response stream:
  - tx_byte and tx_byte_valid hold stable until tx_byte_ready.
  - After a transfer, the next byte is presented in the following cycle.
  - After the last byte is accepted: IDLE.

## Timing
- Reset values: psel, penable, pwrite, tx_byte_valid, busy, rx_drop and frame_err all 0; paddr=0, pwdata=0, tx_byte=0; state IDLE; all counters and shift registers 0.
- Reset mid-transfer immediately drops psel/penable and abandons any response.
- Last frame byte pulse at cycle N → SETUP (psel=1) at N+1 → ACCESS (penable=1) at N+2.
- With pready=1 at N+2: psel=0 and tx_byte_valid=1 (0x06 or 0x15) at N+3.
- Unknown command byte at cycle N → tx_byte_valid=1 with 0x3F at N+1.
- An rx_byte_valid in the same cycle that RESP completes is dropped, because state is still RESP.
- pwrite is updated only in SETUP and holds through the transfer; pwdata for reads is don't-care and holds its previous value.

## Test plan
- Write: bytes 57 00 08 00 00 00 01, pready=1 → one APB write with paddr=0x008, pwdata=0x00000001; psel high exactly 2 cycles; response 06.
- Read: bytes 52 00 04, prdata=0x0000000C, pready held low 3 access cycles → response 06 00 00 00 0C.
- Error and timeout:
  - pslverr=1 on a write → response 15.
  - pready never asserted on a read → psel drops after 256 ACCESS cycles, response 15.
- Unknown command and drop: byte 41 → response 3F with no psel activity. A byte injected during ACCESS → rx_drop pulse, frame result unchanged.
- Frame timeout (FRAME_TIMEOUT=100): bytes 57 12 then silence → frame_err pulse after 100 cycles, no response. A following 52 00 00 completes normally.
- Backpressure and reset:
  - tx_byte_ready toggling 1-of-3 during a read response → all 5 bytes in order, each held stable.
  - rst_n low during ACCESS → all outputs return to reset values asynchronously.
